// File: rtl/chacha_stream_xor.sv
`default_nettype none
// ============================================================================
// Module      : chacha_stream_xor
// Description : Front end for the chacha keystream core. Writes the 64-bit
//               block counter into the core, drains one keystream block into
//               a local buffer, then XORs it byte-by-byte onto a valid/ready
//               plaintext stream. Moves to the next counter value at block
//               end and returns to idle at end of message.
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_stream_xor #(
    parameter int BLK_BYTES = 64,
    parameter int CTR_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] ctr_init,
    output logic        busy,
    output logic        ctr_ovf,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        ks_wr_ctr,
    output logic [7:0]  ks_data_in,
    output logic        ks_hold,
    input  logic        ks_blk_ready,
    output logic        ks_rd_blk,
    input  logic [7:0]  ks_data_out
);

    localparam int              IDX_W    = $clog2(BLK_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_CTR = IDX_W'(CTR_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_FETCH  = 3'd3,
        S_STREAM = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [63:0]      ctr;
    logic [IDX_W-1:0] idx;      // load byte, fetch address or stream position
    logic [7:0]       ks_buf [0:BLK_BYTES-1];
    logic             buf_we;
    logic [IDX_W-1:0] buf_addr;
    logic             accept;
    logic             ctr_inc;

    // The core never stalls the hold input in this system.
    assign ks_hold = 1'b0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all combinational strobes to the core and the stream.
    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        in_ready   = 1'b0;
        ks_wr_ctr  = 1'b0;
        ks_data_in = 8'h00;
        ks_rd_blk  = 1'b0;
        buf_we     = 1'b0;
        buf_addr   = idx;
        accept     = 1'b0;
        ctr_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // Least significant counter byte goes out first.
                ks_data_in = 8'(ctr >> {idx, 3'b000});
                ks_wr_ctr  = (idx == '0);
                if (idx == LAST_CTR) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Byte 0 is already on the bus when the read strobe goes out.
                if (ks_blk_ready) begin
                    ks_rd_blk = 1'b1;
                    buf_we    = 1'b1;
                    buf_addr  = '0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                buf_we = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                in_ready = !out_valid || out_ready;
                accept   = in_valid && in_ready;
                if (accept) begin
                    if (in_last) begin
                        ctr_inc   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (idx == LAST_IDX) begin
                        ctr_inc   = 1'b1;
                        state_nxt = S_LOAD;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Keystream buffer; contents are don't-care until refilled, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            ks_buf[buf_addr] <= ks_data_out;
        end
    end

    // Counter, position index, overflow flag and the single output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr       <= '0;
            idx       <= '0;
            ctr_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ctr     <= ctr_init;
                        ctr_ovf <= 1'b0;
                        idx     <= '0;
                    end
                end
                S_LOAD: begin
                    idx <= (idx == LAST_CTR) ? '0 : idx + IDX_ONE;
                end
                S_WAIT: begin
                    if (ks_blk_ready) begin
                        idx <= IDX_ONE;
                    end
                end
                S_FETCH: begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
                end
                S_STREAM: begin
                    if (accept) begin
                        idx <= (in_last || idx == LAST_IDX) ? '0 : idx + IDX_ONE;
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase

            if (ctr_inc) begin
                ctr <= ctr + 64'd1;
                if (&ctr) begin
                    ctr_ovf <= 1'b1;
                end
            end

            // A pending byte is held across state changes until taken.
            if (accept) begin
                out_data  <= in_data ^ ks_buf[idx];
                out_last  <= in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/chacha_stream_xor.md
Name: chacha_stream_xor

Overview:
Stream-cipher front end that sits directly downstream of the chacha keystream core. It writes the 64-bit block counter into the core and waits for blk_ready. It then drains the 64-byte keystream block into a local buffer and XORs it byte-by-byte with a valid/ready plaintext stream. Key and nonce are loaded into the core by the host before start; this block owns only the counter-write, read, and hold controls of the core.

Parameters:
BLK_BYTES, 64, keystream bytes per block; fixed by the core, not overridable in practice.
CTR_BYTES, 8, counter bytes written per block.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; latches ctr_init and begins processing (ignored unless idle)
ctr_init  in  64  first block counter value
busy  out  1  high in every state except S_IDLE
ctr_ovf  out  1  sticky; set when the counter wraps from all-ones to 0
in_valid  in  1  plaintext byte valid
in_ready  out  1  plaintext byte accepted when in_valid & in_ready
in_data  in  8  plaintext byte
in_last  in  1  final byte of the message, qualified by in_valid
out_valid  out  1  ciphertext byte valid
out_ready  in  1  downstream accept
out_data  out  8  ciphertext byte
out_last  out  1  marks the byte derived from in_last
ks_wr_ctr  out  1  counter-write strobe to the core
ks_data_in  out  8  counter byte bus to the core
ks_hold  out  1  tied 0
ks_blk_ready  in  1  core block available
ks_rd_blk  out  1  read strobe to the core
ks_data_out  in  8  core keystream byte

Behaviour:
- Reset, synchronous and active-low, from any state including mid-load or mid-fetch:
  - state <= S_IDLE; ctr, idx, byte counters <= 0; ctr_ovf <= 0.
  - out_valid, out_last, out_data, ks_wr_ctr, ks_rd_blk, ks_data_in, busy <= 0.
  - The buffer is not cleared.
- S_IDLE:
  - in_ready = 0.
  - start: ctr <= ctr_init, go S_LOAD.
- S_LOAD, 8 cycles, k = 0..7:
  - ks_data_in = ctr[8k+7:8k], least significant byte first.
  - ks_wr_ctr = 1 in cycle k=0 only.
  - After k=7, go S_WAIT.
- S_WAIT:
  - Stay until ks_blk_ready = 1.
  - In that cycle assert ks_rd_blk for exactly one cycle and capture ks_data_out into buf[0], same cycle.
  - Go S_FETCH with idx = 1.
- S_FETCH:
  - Each cycle buf[idx] <= ks_data_out; idx++.
  - The core cannot stall, so no wait states are allowed.
  - After buf[63] is captured: idx <= 0, go S_STREAM.
- S_STREAM:
  - in_ready = !out_valid | out_ready (single output register stage).
  - On accept:
    - out_data <= in_data ^ buf[idx]; out_last <= in_last; out_valid <= 1; idx++.
    - If in_last: ctr <= ctr+1, go S_IDLE. The rest of the block is discarded and never reused.
    - Else if idx == 63: ctr <= ctr+1, go S_LOAD.
  - in_last on byte 63 takes the S_IDLE path.
- out_valid clears on out_ready when no new accept occurs that cycle. A pending output byte survives the FSM moving to S_LOAD or S_IDLE.
- Counter wrap:
  - ctr = 2^64-1 increments to 0 and sets ctr_ovf.
  - Processing continues.
  - ctr_ovf clears only on reset or a new start.
- start outside S_IDLE is ignored. start in the same cycle as reset is ignored.
- in_valid outside S_STREAM is not accepted; in_ready = 0.

Test Plan:
- Counter load: ctr_init = 0x0807060504030201, start → ks_data_in = 01,02,...,08 on 8 consecutive cycles; ks_wr_ctr high on the 01 cycle only; busy = 1.
- Single block: core model returns byte i = i^0xA5 after a blk_ready delay of 20 cycles; send 64 zero bytes with in_last on byte 63 → out_data = i^0xA5, out_last on the 64th; ks_rd_blk is a single pulse; final state idle; next counter = init+1.
- Multi-block: 130 bytes from ctr_init = 5 → three S_LOAD sequences writing counters 5, 6, 7; bytes 64 and 128 use keystream from the new blocks; no byte lost or duplicated.
- Backpressure: out_ready toggles 1,0,0,1 pseudo-randomly, in_valid with gaps → output byte sequence identical to the unthrottled run; in_ready never high while out_valid & !out_ready.
- Wrap: ctr_init = 0xFFFFFFFFFFFFFFFF, 70 bytes → second load writes counter 0; ctr_ovf = 1.
- Reset mid-fetch: assert rst_n = 0 at fetch cycle 30 → next cycle busy = 0, out_valid = 0, ks_rd_blk = 0; a fresh start runs a full correct block.
